ramp_code_capture: RTL and testbench

Sits directly downstream of the per-pixel comparator rising-edge detector in the single-slope ADC array. Runs the shared ramp counter for one conversion. Latches the counter value into a per-pixel code register on each pixel's first enable pulse. After the conversion it streams all pixel codes out, in pixel order, over a valid/ready interface.

---
 rtl/adc_pkg.sv | 15 +
 rtl/pixel_code_bank.sv | 61 ++++++
 rtl/ramp_code_capture.sv | 116 +++++++++++
 tb/tb_ramp_code_capture.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the single-slope ADC ramp/capture logic.
package adc_pkg;

    localparam int ADC_NUM_PIXELS = 50;
    localparam int ADC_CODE_W     = 10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_READOUT = 2'd2;

    function automatic int max_code(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/pixel_code_bank.sv
// Per-pixel code and captured-flag registers with first-edge capture and readout mux.
module pixel_code_bank
    import adc_pkg::*;
#(
    parameter int NUM_PIXELS = ADC_NUM_PIXELS,
    parameter int CODE_W     = ADC_CODE_W,
    parameter int IDX_W      = $clog2(NUM_PIXELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  capture_en_i,
    input  logic [NUM_PIXELS-1:0] enable_i,
    input  logic [CODE_W-1:0]     ramp_cnt_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic                  all_captured_nxt_o,
    output logic [CODE_W-1:0]     rd_code_o,
    output logic                  rd_overflow_o
);

    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(max_code(CODE_W));

    logic [CODE_W-1:0]     code_q [NUM_PIXELS];
    logic [NUM_PIXELS-1:0] captured_q;
    logic [NUM_PIXELS-1:0] captured_d;
    logic [NUM_PIXELS-1:0] first_edge;

    always_comb begin
        first_edge = '0;
        captured_d = captured_q;
        if (clear_i) begin
            captured_d = '0;
        end else if (capture_en_i) begin
            first_edge = enable_i & ~captured_q;
            captured_d = captured_q | enable_i;
        end
    end

    // Includes this cycle's edges so the FSM can exit in the same cycle.
    assign all_captured_nxt_o = &(captured_q | enable_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            captured_q <= '0;
        end else begin
            captured_q <= captured_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (first_edge[i]) begin
                code_q[i] <= ramp_cnt_i;
            end
        end
    end

    assign rd_overflow_o = ~captured_q[rd_idx_i];
    assign rd_code_o     = captured_q[rd_idx_i] ? code_q[rd_idx_i] : MAX_CODE;

endmodule

// File: rtl/ramp_code_capture.sv
// Ramp counter FSM for one single-slope conversion plus valid/ready readout of all pixel codes.
//   state      | meaning
//   ST_IDLE    | waiting for start; enables ignored
//   ST_CONVERT | ramp running, counter stepping, first edges latched
//   ST_READOUT | streaming codes in pixel order
module ramp_code_capture
    import adc_pkg::*;
#(
    parameter int NUM_PIXELS = ADC_NUM_PIXELS,
    parameter int CODE_W     = ADC_CODE_W,
    parameter int IDX_W      = $clog2(NUM_PIXELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_PIXELS-1:0] enable,
    output logic                  ramp_run,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_pix_idx,
    output logic [CODE_W-1:0]     out_code,
    output logic                  out_overflow,
    output logic                  frame_done
);

    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(max_code(CODE_W));
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    logic [1:0]        state_q, state_d;
    logic [CODE_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              frame_done_q, frame_done_d;
    logic              clear_flags;
    logic              all_captured_nxt;
    logic [CODE_W-1:0] bank_code;
    logic              bank_overflow;

    always_comb begin
        state_d      = state_q;
        ramp_cnt_d   = ramp_cnt_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        clear_flags  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear_flags = 1'b1;
                    ramp_cnt_d  = '0;
                    state_d     = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (ramp_cnt_q == MAX_CODE || all_captured_nxt) begin
                    state_d = ST_READOUT;
                    idx_d   = '0;
                end else begin
                    ramp_cnt_d = ramp_cnt_q + 1'b1;
                end
            end
            ST_READOUT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d      = ST_IDLE;
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ramp_cnt_q   <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ramp_cnt_q   <= ramp_cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    pixel_code_bank #(
        .NUM_PIXELS (NUM_PIXELS),
        .CODE_W     (CODE_W),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk                (clk),
        .reset              (reset),
        .clear_i            (clear_flags),
        .capture_en_i       (state_q == ST_CONVERT),
        .enable_i           (enable),
        .ramp_cnt_i         (ramp_cnt_q),
        .rd_idx_i           (idx_q),
        .all_captured_nxt_o (all_captured_nxt),
        .rd_code_o          (bank_code),
        .rd_overflow_o      (bank_overflow)
    );

    // Readout fields are gated so they read zero outside READOUT.
    assign ramp_run     = (state_q == ST_CONVERT);
    assign busy         = (state_q != ST_IDLE);
    assign out_valid    = (state_q == ST_READOUT);
    assign out_pix_idx  = out_valid ? idx_q : '0;
    assign out_code     = out_valid ? bank_code : '0;
    assign out_overflow = out_valid & bank_overflow;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_ramp_code_capture.sv
// Randomized and directed bench for ramp_code_capture against a frame-level reference model.
module tb_ramp_code_capture;

    localparam int NP  = 4;
    localparam int CW  = 4;
    localparam int IW  = 2;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NP-1:0] enable;
    logic          ramp_run;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_pix_idx;
    logic [CW-1:0] out_code;
    logic          out_overflow;
    logic          frame_done;

    int n_vec = 0;
    int n_err = 0;

    logic [NP-1:0] ev [16];
    int            exp_code [NP];
    int            exp_ovf  [NP];
    int            exp_len;
    bit            pending_start = 1'b0;

    always #5 clk = ~clk;

    ramp_code_capture #(.NUM_PIXELS(NP), .CODE_W(CW), .IDX_W(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enable       (enable),
        .ramp_run     (ramp_run),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pix_idx  (out_pix_idx),
        .out_code     (out_code),
        .out_overflow (out_overflow),
        .frame_done   (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first pulse per pixel wins; ramp stops at full scale or once every pixel has fired.
    function automatic void model();
        logic [NP-1:0] cap;
        cap     = '0;
        exp_len = MAX + 1;
        for (int k = 0; k <= MAX; k++) begin
            for (int i = 0; i < NP; i++) begin
                if (ev[k][i] && !cap[i]) begin
                    cap[i]      = 1'b1;
                    exp_code[i] = k;
                end
            end
            if (&cap) begin
                exp_len = k + 1;
                break;
            end
        end
        for (int i = 0; i < NP; i++) begin
            exp_ovf[i] = cap[i] ? 0 : 1;
            if (!cap[i]) exp_code[i] = MAX;
        end
    endfunction

    task automatic clear_ev();
        for (int k = 0; k < 16; k++) ev[k] = '0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ramp_run"}, ramp_run, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_idx"}, out_pix_idx, 0);
        chk({tag, "_code"}, out_code, 0);
        chk({tag, "_ovf"}, out_overflow, 0);
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_frame(input int ready_mode, input bit junk_idle, input bit inj_start,
                             input bit chain_next);
        int  k;
        int  p;
        int  cyc;
        bit  r;
        model();
        if (!pending_start) begin
            if (junk_idle) begin
                enable = '1;
                tick();
                tick();
                chk("idle_no_busy", busy, 0);
            end
            start = 1'b1;
            tick();
            start  = 1'b0;
            enable = '0;
        end
        pending_start = 1'b0;

        k = 0;
        while (ramp_run && k < MAX + 4) begin
            chk("busy_in_convert", busy, 1);
            enable = (k <= MAX) ? ev[k] : '0;
            start  = inj_start && (k == 2);
            tick();
            k++;
        end
        enable = '0;
        start  = 1'b0;
        chk("ramp_len", k, exp_len);

        p   = 0;
        cyc = 0;
        while (p < NP && cyc < 200) begin
            chk("valid", out_valid, 1);
            chk("busy_in_readout", busy, 1);
            chk("pix_idx", out_pix_idx, p);
            chk("code", out_code, exp_code[p]);
            chk("overflow", out_overflow, exp_ovf[p]);
            chk("no_early_done", frame_done, 0);
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = $urandom_range(0, 1) != 0;
            endcase
            out_ready = r;
            start     = inj_start && (cyc == 0);
            tick();
            cyc++;
            if (r) p++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        chk("words_accepted", p, NP);
        chk("frame_done_pulse", frame_done, 1);
        chk_idle_outputs("after_frame");
        if (chain_next) begin
            start = 1'b1;
            tick();
            start         = 1'b0;
            pending_start = 1'b1;
            chk("chained_start", ramp_run, 1);
        end else begin
            tick();
        end
        chk("frame_done_single", frame_done, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        enable    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_frame_done", frame_done, 0);
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // nominal: exit early once all four have fired at 12
        clear_ev();
        ev[3] = 4'b0001; ev[7] = 4'b0110; ev[12] = 4'b1000;
        run_frame(0, 0, 0, 0);

        // pixel 2 never fires: full ramp and overflow
        clear_ev();
        ev[1] = 4'b0001; ev[4] = 4'b0010; ev[9] = 4'b1000;
        run_frame(0, 0, 0, 0);

        // duplicate edge on pixel 0
        clear_ev();
        ev[2] = 4'b0001; ev[5] = 4'b0010; ev[6] = 4'b0100; ev[9] = 4'b0001; ev[10] = 4'b1000;
        run_frame(1, 0, 0, 0);

        // IDLE enables ignored, start while busy ignored, chain start on frame_done
        clear_ev();
        ev[4] = 4'b0010; ev[8] = 4'b1000; ev[11] = 4'b0001;
        run_frame(1, 1, 1, 1);

        // boundary captures at 0 and at full scale
        clear_ev();
        ev[0] = 4'b0011; ev[15] = 4'b1100;
        run_frame(0, 0, 0, 0);

        // reset at ramp_cnt 5 aborts the frame
        clear_ev();
        ev[1] = 4'b0001; ev[3] = 4'b0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enable = ev[k];
            tick();
        end
        chk("pre_reset_running", ramp_run, 1);
        reset  = 1'b1;
        enable = 4'b1111;
        tick();
        reset  = 1'b0;
        enable = '0;
        chk("abort_frame_done", frame_done, 0);
        chk_idle_outputs("abort");
        tick();
        chk("abort_no_done_later", frame_done, 0);
        chk("abort_stays_idle", busy, 0);
        clear_ev();
        ev[6] = 4'b0100; ev[7] = 4'b1000;
        run_frame(2, 0, 0, 0);

        for (int f = 0; f < 25; f++) begin
            clear_ev();
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 4) != 0) ev[$urandom_range(0, 15)][i] = 1'b1;
            end
            for (int k = 0; k < 16; k++) begin
                ev[k] = ev[k] | NP'($urandom & $urandom & $urandom);
            end
            run_frame(2, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
